pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 165 ++++++++++++++++
 tb/tb_pc_stack_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program counter with an integrated hardware return stack.
//   Commands are prioritised RET > CALL > PC_LD > PC_INC; only the highest
//   asserted command executes on each rising edge of CLK.
//
//   Optional feature macro: PC_STACK_OVF_TRAP_EN
//     When defined, a faulting CALL (stack full) or RET (stack empty) forces
//     PC_COUNT to all-ones. Otherwise a faulting CALL still loads D_IN and a
//     faulting RET leaves the PC unchanged. STK_ERR is set in both builds.
//
// Parameters
//   AW     program-address width in bits
//   DEPTH  return-stack entries (power of two, 2..32)
//
// Ports
//   CLK        system clock, rising edge active
//   RST_N      asynchronous active-low reset
//   D_IN       next-address value from the upstream PC source mux
//   PC_LD      load D_IN into the PC
//   PC_INC     increment the PC (wraps modulo 2^AW)
//   CALL       push PC_COUNT+1, then load D_IN
//   RET        pop top of stack into the PC
//   PC_COUNT   registered current program address
//   TOS        registered top-of-stack value, 0 when empty
//   STK_FULL   stack holds DEPTH entries
//   STK_EMPTY  stack holds no entries
//   STK_ERR    sticky overflow/underflow flag, cleared only by reset

module pc_stack_unit #(
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] D_IN,
  input  logic          PC_LD,
  input  logic          PC_INC,
  input  logic          CALL,
  input  logic          RET,
  output logic [AW-1:0] PC_COUNT,
  output logic [AW-1:0] TOS,
  output logic          STK_FULL,
  output logic          STK_EMPTY,
  output logic          STK_ERR
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_LD,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  cmd_e            cmd;

  logic [AW-1:0]   pc_q;
  logic [AW-1:0]   tos_q;
  logic [SPW-1:0]  sp_q;
  logic            err_q;
  logic [AW-1:0]   mem [DEPTH];

  logic [AW-1:0]   pc_d;
  logic [AW-1:0]   tos_d;
  logic [SPW-1:0]  sp_d;
  logic            err_d;
  logic            push_en;

  logic            full;
  logic            empty;
  logic [AW-1:0]   pc_plus1;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   below_idx;

  assign full      = (sp_q == SP_MAX);
  assign empty     = (sp_q == '0);
  assign pc_plus1  = pc_q + AW'(1);
  // Next free slot; only used when not full, so the low bits suffice.
  assign wr_idx    = IW'(sp_q);
  // Entry beneath the current top; becomes the new top after a pop.
  assign below_idx = IW'(sp_q - SPW'(2));

  always_comb begin
    cmd = CMD_NONE;
    if (RET)         cmd = CMD_RET;
    else if (CALL)   cmd = CMD_CALL;
    else if (PC_LD)  cmd = CMD_LD;
    else if (PC_INC) cmd = CMD_INC;
  end

  always_comb begin
    pc_d    = pc_q;
    tos_d   = tos_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    unique case (cmd)
      CMD_INC: pc_d = pc_plus1;
      CMD_LD:  pc_d = D_IN;
      CMD_CALL: begin
        if (full) begin
          err_d = 1'b1;
`ifdef PC_STACK_OVF_TRAP_EN
          pc_d  = '1;
`else
          pc_d  = D_IN;
`endif
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + SPW'(1);
          tos_d   = pc_plus1;
          pc_d    = D_IN;
        end
      end
      CMD_RET: begin
        if (empty) begin
          err_d = 1'b1;
`ifdef PC_STACK_OVF_TRAP_EN
          pc_d  = '1;
`endif
        end else begin
          pc_d  = tos_q;
          sp_d  = sp_q - SPW'(1);
          // TOS is kept as its own register so it reads 0 when empty
          // without exposing stale storage.
          tos_d = (sp_q == SPW'(1)) ? '0 : mem[below_idx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= '0;
      tos_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      tos_q <= tos_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Storage is not reset; the write is gated by RST_N so a CALL held
  // during reset leaves no trace.
  always_ff @(posedge CLK) begin
    if (RST_N && push_en) begin
      mem[wr_idx] <= pc_plus1;
    end
  end

  assign PC_COUNT  = pc_q;
  assign TOS       = tos_q;
  assign STK_FULL  = full;
  assign STK_EMPTY = empty;
  assign STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int VW    = 2*AW + 3;

  logic          CLK;
  logic          RST_N;
  logic [AW-1:0] D_IN;
  logic          PC_LD;
  logic          PC_INC;
  logic          CALL;
  logic          RET;
  logic [AW-1:0] PC_COUNT;
  logic [AW-1:0] TOS;
  logic          STK_FULL;
  logic          STK_EMPTY;
  logic          STK_ERR;

  int checks = 0;
  int errors = 0;

  // Reference model: PC as an integer, stack as a queue.
  int unsigned     m_pc;
  int unsigned     m_stk[$];
  bit              m_err;

`ifdef PC_STACK_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int unsigned MOD = 1 << AW;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .CALL(CALL), .RET(RET), .PC_COUNT(PC_COUNT), .TOS(TOS),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_pc  = 0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_step(bit r, bit c, bit l, bit i, int unsigned d);
    if (r) begin
      if (m_stk.size() == 0) begin
        m_err = 1'b1;
        if (TRAP) m_pc = MOD - 1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin
        m_err = 1'b1;
        m_pc  = TRAP ? MOD - 1 : d;
      end else begin
        m_stk.push_back((m_pc + 1) % MOD);
        m_pc = d;
      end
    end else if (l) begin
      m_pc = d;
    end else if (i) begin
      m_pc = (m_pc + 1) % MOD;
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    int unsigned t;
    t = (m_stk.size() == 0) ? 0 : m_stk[$];
    return {AW'(m_pc), AW'(t), (m_stk.size() == DEPTH), (m_stk.size() == 0), m_err};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {PC_COUNT, TOS, STK_FULL, STK_EMPTY, STK_ERR};
  endfunction

  // Drive one command set at the falling edge, advance the model at the
  // rising edge, and return 1 time unit later for sampling.
  task automatic step(input bit r, input bit c, input bit l, input bit i,
                      input logic [AW-1:0] d);
    @(negedge CLK);
    RET = r; CALL = c; PC_LD = l; PC_INC = i; D_IN = d;
    @(posedge CLK);
    model_step(r, c, l, i, int'(d));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    RET = 0; CALL = 0; PC_LD = 0; PC_INC = 0; D_IN = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_inc();
    logic [AW-1:0] exp_pc;
    apply_reset();
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 1, '0);
      exp_pc = AW'(k);
      checks++;
      if (PC_COUNT !== exp_pc || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL inc_%0d: got pc %h vec %h expected pc %h vec %h",
                 k, PC_COUNT, dut_vec(), exp_pc, model_vec());
      end
    end
  endtask

  task automatic test_ld_wrap();
    apply_reset();
    step(0, 0, 1, 0, 10'h3FF);
    checks++;
    if (PC_COUNT !== 10'h3FF) begin
      errors++;
      $display("FAIL ld_3ff: got %h expected 3ff", PC_COUNT);
    end
    step(0, 0, 0, 1, '0);
    checks++;
    if (PC_COUNT !== 10'h000 || STK_ERR !== 1'b0) begin
      errors++;
      $display("FAIL inc_wrap: got pc %h err %b expected pc 000 err 0", PC_COUNT, STK_ERR);
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    step(0, 0, 1, 0, 10'h010);
    step(0, 1, 0, 0, 10'h200);
    checks++;
    if (PC_COUNT !== 10'h200 || TOS !== 10'h011 || STK_EMPTY !== 1'b0) begin
      errors++;
      $display("FAIL call: got pc %h tos %h empty %b expected pc 200 tos 011 empty 0",
               PC_COUNT, TOS, STK_EMPTY);
    end
    step(1, 0, 0, 0, '0);
    checks++;
    if (PC_COUNT !== 10'h011 || STK_EMPTY !== 1'b1 || TOS !== 10'h000) begin
      errors++;
      $display("FAIL ret: got pc %h empty %b tos %h expected pc 011 empty 1 tos 000",
               PC_COUNT, STK_EMPTY, TOS);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_pc;
    apply_reset();
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, 0, 0, AW'($urandom));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL fill_%0d: got %h expected %h", k, dut_vec(), model_vec());
      end
    end
    step(0, 1, 0, 0, 10'h055);
    exp_pc = TRAP ? 10'h3FF : 10'h055;
    checks++;
    if (STK_FULL !== 1'b1 || STK_ERR !== 1'b1 || PC_COUNT !== exp_pc ||
        dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL overflow: got full %b err %b pc %h vec %h expected full 1 err 1 pc %h vec %h",
               STK_FULL, STK_ERR, PC_COUNT, dut_vec(), exp_pc, model_vec());
    end
    // Error is sticky across ordinary commands.
    step(0, 0, 0, 1, '0);
    checks++;
    if (STK_ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", STK_ERR);
    end
  endtask

  task automatic test_underflow();
    logic [AW-1:0] exp_pc;
    apply_reset();
    step(0, 0, 1, 0, 10'h0AB);
    step(1, 0, 0, 0, '0);
    exp_pc = TRAP ? 10'h3FF : 10'h0AB;
    checks++;
    if (STK_ERR !== 1'b1 || PC_COUNT !== exp_pc || STK_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got err %b pc %h empty %b expected err 1 pc %h empty 1",
               STK_ERR, PC_COUNT, STK_EMPTY, exp_pc);
    end
  endtask

  task automatic test_priority_async_reset();
    apply_reset();
    step(0, 0, 1, 0, 10'h010);
    step(0, 1, 0, 0, 10'h200);
    step(1, 1, 1, 1, 10'h123);
    checks++;
    if (PC_COUNT !== 10'h011 || STK_EMPTY !== 1'b1 || STK_ERR !== 1'b0) begin
      errors++;
      $display("FAIL priority: got pc %h empty %b err %b expected pc 011 empty 1 err 0",
               PC_COUNT, STK_EMPTY, STK_ERR);
    end
    // Put state in non-reset values, then reset between edges.
    step(0, 1, 0, 0, 10'h2AA);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {10'h000, 10'h000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(),
               {10'h000, 10'h000, 1'b0, 1'b1, 1'b0});
    end
    // CALL held through reset must leave no trace after release.
    @(negedge CLK);
    CALL = 1'b1; D_IN = 10'h155;
    @(posedge CLK);
    @(negedge CLK);
    CALL = 1'b0; RST_N = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_mid_call: got %h expected %h", dut_vec(), model_vec());
    end
    // First command after release executes on the first rising edge.
    step(0, 0, 0, 1, '0);
    checks++;
    if (PC_COUNT !== 10'h001 || STK_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL first_cmd: got pc %h empty %b expected pc 001 empty 1", PC_COUNT, STK_EMPTY);
    end
  endtask

  task automatic test_random();
    bit r, c, l, i;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) apply_reset();
      r = ($urandom_range(0, 99) < 25);
      c = ($urandom_range(0, 99) < 30);
      l = ($urandom_range(0, 99) < 20);
      i = ($urandom_range(0, 99) < 50);
      step(r, c, l, i, AW'($urandom));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_%0d: cmd r%b c%b l%b i%b got %h expected %h",
                 n, r, c, l, i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; D_IN = '0; PC_LD = 0; PC_INC = 0; CALL = 0; RET = 0;
    model_reset();
    test_reset();
    test_inc();
    test_ld_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
